// File: rtl/fp_int_regfile.sv
// fp_int_regfile: integer + floating-point register file with fcsr and FP busy-bit scoreboard.
// Ports: clk, RST (async active-low); ra1..3/rb1..3 -> rd1..3 combinational reads (rb: 0 int, 1 fp);
//        we/wb/wa/wd single write port; flag_valid/flag_in sticky flag accumulation;
//        csr_en/csr_op/csr_sel/csr_wdata -> csr_rdata CSR access; frm/fflags current fcsr fields;
//        sb_set/sb_addr scoreboard issue; hazard stall request.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports and to the hazard check.
module fp_int_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   ra3,
    input  logic            rb1,
    input  logic            rb2,
    input  logic            rb3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] rd3,
    input  logic            we,
    input  logic            wb,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            flag_valid,
    input  logic [4:0]      flag_in,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [1:0]      csr_sel,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      csr_rdata,
    output logic [2:0]      frm,
    output logic [4:0]      fflags,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            hazard
);
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic [XLEN-1:0] ireg [NREG];
    logic [XLEN-1:0] freg [NREG];
    logic [NREG-1:0] busy, busy_nx;
    logic [7:0] fcsr;
    logic [2:0][AW-1:0] ra;
    logic [2:0] rb, rhz;
    logic [2:0][XLEN-1:0] rd;
    logic [4:0] ff_u, ff_nx;
    logic [2:0] rm_v, rm_u, rm_nx;
    logic sel_ff, sel_rm;
    assign ra = {ra3, ra2, ra1};
    assign rb = {rb3, rb2, rb1};
    assign rd1 = rd[0];
    assign rd2 = rd[1];
    assign rd3 = rd[2];
    assign frm = fcsr[7:5];
    assign fflags = fcsr[4:0];
    // Forwarding and the scoreboard-clear exemption only exist in the bypass build;
    // int x0 is masked last so it wins over forwarding.
    always_comb begin
        rd = '0;
        rhz = '0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = rb[i] ? freg[ra[i]] : ireg[ra[i]];
            if (BYP && we && wb == rb[i] && wa == ra[i]) rd[i] = wd;
            if (!rb[i] && ra[i] == '0) rd[i] = '0;
            rhz[i] = rb[i] && busy[ra[i]] && !(BYP && we && wb && wa == ra[i]);
        end
    end
    assign hazard = (|rhz) | (sb_set & busy[sb_addr]);
    // A full-fcsr access feeds frm from operand bits [7:5]; a frm-only access uses [2:0].
    assign sel_ff = csr_en & csr_sel[0];
    assign sel_rm = csr_en & csr_sel[1];
    assign rm_v = (csr_sel == 2'b11) ? csr_wdata[7:5] : csr_wdata[2:0];
    assign ff_u = csr_op == 2'b01 ? csr_wdata[4:0] : csr_op == 2'b10 ? fcsr[4:0] | csr_wdata[4:0] :
                  csr_op == 2'b11 ? fcsr[4:0] & ~csr_wdata[4:0] : fcsr[4:0];
    assign rm_u = csr_op == 2'b01 ? rm_v : csr_op == 2'b10 ? fcsr[7:5] | rm_v :
                  csr_op == 2'b11 ? fcsr[7:5] & ~rm_v : fcsr[7:5];
    assign ff_nx = (sel_ff ? ff_u : fcsr[4:0]) | (flag_valid ? flag_in : 5'b0);
    assign rm_nx = sel_rm ? rm_u : fcsr[7:5];
    assign csr_rdata = csr_sel == 2'b01 ? {3'b0, fcsr[4:0]} : csr_sel == 2'b10 ? {5'b0, fcsr[7:5]} :
                       csr_sel == 2'b11 ? fcsr : 8'h00;
    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        busy_nx = busy;
        if (we && wb) busy_nx[wa] = 1'b0;
        if (sb_set) busy_nx[sb_addr] = 1'b1;
    end
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) begin
                ireg[i] <= '0;
                freg[i] <= '0;
            end
            fcsr <= '0;
            busy <= '0;
        end else begin
            if (we && wb) freg[wa] <= wd;
            if (we && !wb && wa != '0) ireg[wa] <= wd;
            fcsr <= {rm_nx, ff_nx};
            busy <= busy_nx;
        end
    end
endmodule

// File: tb/tb_fp_int_regfile.sv
// tb_fp_int_regfile: directed and randomized checks of fp_int_regfile against a behavioural model.
module tb_fp_int_regfile;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic RST = 1'b0;
    logic [AW-1:0] ra1, ra2, ra3, wa, sb_addr;
    logic rb1, rb2, rb3, we, wb, flag_valid, csr_en, sb_set, hazard;
    logic [XLEN-1:0] rd1, rd2, rd3, wd;
    logic [4:0] flag_in, fflags;
    logic [1:0] csr_op, csr_sel;
    logic [7:0] csr_wdata, csr_rdata;
    logic [2:0] frm;
    int checks = 0;
    int failures = 0;
    logic [31:0] mi [NREG];
    logic [31:0] mf [NREG];
    logic mbusy [NREG];
    logic [7:0] mfcsr;

    always #5 clk = ~clk;

    fp_int_regfile dut (
        .clk(clk), .RST(RST),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .rb1(rb1), .rb2(rb2), .rb3(rb3),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .we(we), .wb(wb), .wa(wa), .wd(wd),
        .flag_valid(flag_valid), .flag_in(flag_in),
        .csr_en(csr_en), .csr_op(csr_op), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .frm(frm), .fflags(fflags),
        .sb_set(sb_set), .sb_addr(sb_addr), .hazard(hazard)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        {ra1, ra2, ra3, rb1, rb2, rb3} = '0;
        {we, wb, wa, wd} = '0;
        {flag_valid, flag_in, csr_en, csr_op, csr_sel, csr_wdata} = '0;
        {sb_set, sb_addr} = '0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            mi[i] = 0;
            mf[i] = 0;
            mbusy[i] = 0;
        end
        mfcsr = 0;
    endtask

    function automatic logic [31:0] m_rd(input logic b, input logic [AW-1:0] a);
        if (!b && a == 0) return 0;
        if (BYP && we && wb == b && wa == a) return wd;
        return b ? mf[a] : mi[a];
    endfunction

    function automatic logic m_port_hz(input logic b, input logic [AW-1:0] a);
        return b && mbusy[a] && !(BYP && we && wb && wa == a);
    endfunction

    function automatic logic [7:0] m_mask(input logic [1:0] sel);
        return sel == 1 ? 8'h1F : sel == 2 ? 8'hE0 : sel == 3 ? 8'hFF : 8'h00;
    endfunction

    task automatic check_all();
        logic [7:0] m = m_mask(csr_sel);
        logic hz = m_port_hz(rb1, ra1) | m_port_hz(rb2, ra2) | m_port_hz(rb3, ra3) |
                   (sb_set && mbusy[sb_addr]);
        chk("rd1", rd1, m_rd(rb1, ra1));
        chk("rd2", rd2, m_rd(rb2, ra2));
        chk("rd3", rd3, m_rd(rb3, ra3));
        chk("hazard", 32'(hazard), 32'(hz));
        chk("csr_rdata", 32'(csr_rdata), 32'((mfcsr & m) >> (csr_sel == 2 ? 5 : 0)));
        chk("frm", 32'(frm), 32'(mfcsr >> 5));
        chk("fflags", 32'(fflags), 32'(mfcsr & 8'h1F));
    endtask

    task automatic tick();
        logic [7:0] m, opnd;
        #1 check_all();
        @(posedge clk);
        if (we && wb) mf[wa] = wd;
        if (we && !wb && wa != 0) mi[wa] = wd;
        if (we && wb) mbusy[wa] = 0;
        if (sb_set) mbusy[sb_addr] = 1;
        if (csr_en && csr_sel != 0) begin
            m = m_mask(csr_sel);
            opnd = csr_sel == 2 ? {csr_wdata[2:0], 5'b0} : csr_wdata & m;
            if (csr_op == 1) mfcsr = (mfcsr & ~m) | opnd;
            if (csr_op == 2) mfcsr = mfcsr | opnd;
            if (csr_op == 3) mfcsr = mfcsr & ~opnd;
        end
        if (flag_valid) mfcsr = mfcsr | {3'b0, flag_in};
        #1;
    endtask

    initial begin
        m_reset();
        idle();
        #2 check_all();
        #5 RST = 1'b1;
        idle(); we = 1; wb = 0; wa = 5; wd = 32'hDEADBEEF; tick();
        idle(); we = 1; wb = 1; wa = 5; wd = 32'h3F800000; tick();
        idle(); ra1 = 5; rb1 = 0; ra2 = 5; rb2 = 1;
        #1 chk("x5", rd1, 32'hDEADBEEF); chk("f5", rd2, 32'h3F800000); tick();
        idle(); we = 1; wb = 0; wa = 0; wd = 32'h12345678; tick();
        idle(); ra1 = 0; rb1 = 0;
        #1 chk("x0", rd1, 32'h0); tick();
        idle(); we = 1; wb = 1; wa = 0; wd = 32'h40000000; tick();
        idle(); ra1 = 0; rb1 = 1;
        #1 chk("f0", rd1, 32'h40000000); tick();
        idle(); we = 1; wb = 1; wa = 7; wd = 32'hAAAA5555; ra3 = 7; rb3 = 1;
        #1 chk("f7_same_cycle", rd3, BYP ? 32'hAAAA5555 : 32'h0); tick();
        idle(); csr_en = 1; csr_op = 2'b01; csr_sel = 2'b11; csr_wdata = 8'hE3; tick();
        idle();
        #1 chk("frm_e3", 32'(frm), 7); chk("fflags_e3", 32'(fflags), 3);
        csr_en = 1; csr_op = 2'b11; csr_sel = 2'b01; csr_wdata = 8'h01; flag_valid = 1; flag_in = 5'h10;
        #1 chk("csr_rdata_pre", 32'(csr_rdata), 3); tick();
        idle();
        #1 chk("fflags_acc", 32'(fflags), 32'h12);
        idle(); sb_set = 1; sb_addr = 9; tick();
        idle(); ra1 = 9; rb1 = 1;
        #1 chk("hz_busy_fp", 32'(hazard), 1);
        rb1 = 0;
        #1 chk("hz_int_read", 32'(hazard), 0);
        rb1 = 1; we = 1; wb = 1; wa = 9; wd = 32'h1;
        #1 chk("hz_clear_cycle", 32'(hazard), BYP ? 0 : 1); tick();
        idle(); ra1 = 9; rb1 = 1;
        #1 chk("hz_after_clear", 32'(hazard), 0); tick();
        idle(); sb_set = 1; sb_addr = 9; tick();
        idle(); sb_set = 1; sb_addr = 9;
        #1 chk("hz_waw", 32'(hazard), 1); tick();
        idle(); we = 1; wb = 1; wa = 9; wd = 32'h2; tick();
        for (int n = 0; n < 600; n++) begin
            ra1 = AW'($urandom_range(0, 7)); ra2 = AW'($urandom_range(0, 7)); ra3 = AW'($urandom_range(0, 7));
            rb1 = 1'($urandom); rb2 = 1'($urandom); rb3 = 1'($urandom);
            we = ($urandom_range(0, 1) == 0); wb = 1'($urandom);
            wa = AW'($urandom_range(0, 7)); wd = $urandom;
            flag_valid = ($urandom_range(0, 2) == 0); flag_in = 5'($urandom);
            csr_en = ($urandom_range(0, 2) == 0); csr_op = 2'($urandom); csr_sel = 2'($urandom);
            csr_wdata = 8'($urandom);
            sb_set = ($urandom_range(0, 3) == 0); sb_addr = AW'($urandom_range(0, 7));
            tick();
        end
        idle(); sb_set = 1; sb_addr = 3; csr_en = 1; csr_op = 2'b01; csr_sel = 2'b01; csr_wdata = 8'h1F; tick();
        idle(); ra1 = 3; rb1 = 1; ra2 = 5; rb2 = 0; ra3 = 5; rb3 = 1;
        #1 chk("hz_pre_reset", 32'(hazard), 1); chk("fflags_pre_reset", 32'(fflags), 32'h1F);
        RST = 1'b0;
        m_reset();
        #1 chk("hz_in_reset", 32'(hazard), 0); chk("fflags_in_reset", 32'(fflags), 0);
        chk("frm_in_reset", 32'(frm), 0); chk("x5_in_reset", rd2, 0); chk("f5_in_reset", rd3, 0);
        we = 1; wb = 0; wa = 5; wd = 32'hFFFFFFFF;
        @(posedge clk);
        #1 RST = 1'b1;
        idle(); ra1 = 5; rb1 = 0; ra2 = 3; rb2 = 1;
        #1 chk("x5_after_reset", rd1, 0); chk("hz_after_reset", 32'(hazard), 0); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
